wb_port_sched: RTL

Write-back scheduler and scoreboard for the 32×32 register file. It arbitrates the register file's single write port between the single-cycle execute result (requester 0) and the long-latency load/memory result (requester 1). It tracks destination registers with outstanding long-latency writes and raises a stall when a decoded source operand depends on one. It sits between the execute/memory stages and the register file's write inputs (`reg_wr`, `rd`, `rd_d`).

---
 rtl/wb_port_sched_pkg.sv | 15 +
 rtl/wb_port_sched_scoreboard.sv | 42 ++++
 rtl/wb_port_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/wb_port_sched_pkg.sv
// Shared constants for the write-back scheduler: register file geometry, grant encoding, starvation default.
// Latency: n/a (constants only).
// Backpressure: n/a.
package wb_port_sched_pkg;

  localparam int REG_LEN = 32;
  localparam int REG_NUM = 32;

  // Grant encoding: which requester owns the write port this cycle
  localparam logic WB_SRC_EX = 1'b0;
  localparam logic WB_SRC_LD = 1'b1;

  localparam int WB_STARVE_LIM = 2;

endpackage

// File: rtl/wb_port_sched_scoreboard.sv
// Pending-write scoreboard: one bit per register with an outstanding long-latency write.
// Latency: set/clear visible one cycle after the edge; lookups are combinational.
// Backpressure: none; set wins over clear on the same index, x0 never marked.
module wb_scoreboard
  import wb_port_sched_pkg::*;
#(
  parameter int ADDR_LEN = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_set_vld,
  input  logic [ADDR_LEN-1:0] i_set_idx,
  input  logic                i_clr_vld,
  input  logic [ADDR_LEN-1:0] i_clr_idx,
  input  logic [ADDR_LEN-1:0] i_rs1,
  input  logic [ADDR_LEN-1:0] i_rs2,
  output logic                o_pend_rs1,
  output logic                o_pend_rs2
);

  logic [REG_NUM-1:0] r_pend;
  logic [REG_NUM-1:0] w_set;
  logic [REG_NUM-1:0] w_clr;

  // One-hot set/clear masks; x0 is excluded from the set mask so it can never become pending
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_vld && (i_set_idx != '0)) w_set[i_set_idx] = 1'b1;
    if (i_clr_vld)                      w_clr[i_clr_idx] = 1'b1;
  end

  // Clear first, then OR in the set so a same-cycle reissue keeps the bit
  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_clr) | w_set;
  end

  assign o_pend_rs1 = r_pend[i_rs1];
  assign o_pend_rs2 = r_pend[i_rs2];

endmodule

// File: rtl/wb_port_sched.sv
// Write-back port arbiter (execute vs load) with starvation guard, registered write stage and load-use stall.
// Latency: accepted write reaches reg_wr/rd/rd_d one cycle later; ready and stall are combinational.
// Backpressure: execute wins by default; load wins once it has waited STARVE_LIM cycles while valid.
module wb_port_sched
  import wb_port_sched_pkg::*;
#(
  parameter int ADDR_LEN   = 5,
  parameter int STARVE_LIM = WB_STARVE_LIM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [ADDR_LEN-1:0] ex_rd,
  input  logic [REG_LEN-1:0]  ex_d,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_LEN-1:0] ld_rd,
  input  logic [REG_LEN-1:0]  ld_d,
  input  logic                iss_valid,
  input  logic [ADDR_LEN-1:0] iss_rd,
  input  logic [ADDR_LEN-1:0] dec_rs1,
  input  logic [ADDR_LEN-1:0] dec_rs2,
  output logic                stall,
  output logic                reg_wr,
  output logic [ADDR_LEN-1:0] rd,
  output logic [REG_LEN-1:0]  rd_d
);

  logic [1:0]          r_wait_cnt;
  logic                r_reg_wr;
  logic [ADDR_LEN-1:0] r_rd;
  logic [REG_LEN-1:0]  r_rd_d;

  logic                w_ld_pri;
  logic                w_src;
  logic                w_ex_xfer;
  logic                w_ld_xfer;
  logic                w_xfer;
  logic [ADDR_LEN-1:0] w_rd;
  logic [REG_LEN-1:0]  w_d;
  logic                w_pend_rs1;
  logic                w_pend_rs2;

  // Grant: load takes the port only when starved or when execute is idle
  always_comb begin
    w_ld_pri  = ld_valid && (r_wait_cnt == 2'(STARVE_LIM));
    w_src     = (w_ld_pri || !ex_valid) ? WB_SRC_LD : WB_SRC_EX;
    ex_ready  = ex_valid && (w_src == WB_SRC_EX);
    ld_ready  = ld_valid && (w_src == WB_SRC_LD);
    w_ex_xfer = ex_valid && ex_ready;
    w_ld_xfer = ld_valid && ld_ready;
    w_xfer    = w_ex_xfer || w_ld_xfer;
    w_rd      = (w_src == WB_SRC_LD) ? ld_rd : ex_rd;
    w_d       = (w_src == WB_SRC_LD) ? ld_d  : ex_d;
  end

  // Starvation counter: counts refused load cycles, saturating at the limit
  always_ff @(posedge clk) begin
    if (!rst_n)                     r_wait_cnt <= '0;
    else if (!ld_valid || w_ld_xfer) r_wait_cnt <= '0;
    else if (r_wait_cnt != 2'(STARVE_LIM)) r_wait_cnt <= r_wait_cnt + 2'd1;
  end

  // Output stage: capture the winner; writes to x0 are accepted but never enabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg_wr <= 1'b0;
      r_rd     <= '0;
      r_rd_d   <= '0;
    end else begin
      r_reg_wr <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_rd   <= w_rd;
        r_rd_d <= w_d;
      end
    end
  end

  wb_scoreboard #(
    .ADDR_LEN (ADDR_LEN)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_vld  (iss_valid),
    .i_set_idx  (iss_rd),
    .i_clr_vld  (w_ld_xfer),
    .i_clr_idx  (ld_rd),
    .i_rs1      (dec_rs1),
    .i_rs2      (dec_rs2),
    .o_pend_rs1 (w_pend_rs1),
    .o_pend_rs2 (w_pend_rs2)
  );

  // Stall on a nonzero source that is pending or still sitting in the output stage
  always_comb begin
    stall = 1'b0;
    if ((dec_rs1 != '0) && (w_pend_rs1 || (r_reg_wr && (r_rd == dec_rs1)))) stall = 1'b1;
    if ((dec_rs2 != '0) && (w_pend_rs2 || (r_reg_wr && (r_rd == dec_rs2)))) stall = 1'b1;
  end

  assign reg_wr = r_reg_wr;
  assign rd     = r_rd;
  assign rd_d   = r_rd_d;

endmodule
